// File: rtl/mem_stage.sv
// Pipeline memory stage: drives the data-memory handshake, lane-aligns stores,
// extracts and extends loads, and registers the MEM/WB write-back values.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_mem_reg,
    input  logic [31:0] ex_mem_instruction,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        mem_misaligned
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_next;
    logic [2:0]  funct3;
    logic        unused_instr_bits;
    logic        memop, is_store, is_load, is_byte, is_half, aligned, misaligned;
    logic [1:0]  byte_off;
    logic [3:0]  cur_be;
    logic [31:0] cur_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_value;
    logic        hold_we;
    logic [31:0] hold_addr;
    logic [3:0]  hold_be;
    logic [31:0] hold_wdata;

    assign funct3            = ex_mem_instruction[14:12];
    assign unused_instr_bits = ^{ex_mem_instruction[31:15], ex_mem_instruction[11:0]};

    // A store wins when both read and write are flagged; funct3 100/101 only size loads.
    always_comb begin
        memop    = ex_mem_read | ex_mem_write;
        is_store = ex_mem_write;
        is_load  = ex_mem_read & ~ex_mem_write;
        byte_off = ex_alu_result[1:0];
        is_byte  = (funct3 == 3'b000) || (is_load && (funct3 == 3'b100));
        is_half  = (funct3 == 3'b001) || (is_load && (funct3 == 3'b101));
        if (is_byte)
            aligned = 1'b1;
        else if (is_half)
            aligned = ~byte_off[0];
        else
            aligned = (byte_off == 2'b00);
        misaligned = memop & ~aligned;
    end

    always_comb begin
        cur_be    = 4'b0000;
        cur_wdata = ex_rs2_data;
        if (is_store) begin
            if (is_byte) begin
                cur_be    = 4'b0001 << byte_off;
                cur_wdata = {4{ex_rs2_data[7:0]}};
            end else if (is_half) begin
                cur_be    = byte_off[1] ? 4'b1100 : 4'b0011;
                cur_wdata = {2{ex_rs2_data[15:0]}};
            end else begin
                cur_be    = 4'b1111;
            end
        end
    end

    // Funct3 bit 2 distinguishes the unsigned load variants.
    always_comb begin
        case (byte_off)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = byte_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (is_byte)
            load_value = {{24{~funct3[2] & ld_byte[7]}}, ld_byte};
        else if (is_half)
            load_value = {{16{~funct3[2] & ld_half[15]}}, ld_half};
        else
            load_value = dmem_rdata;
    end

    always_comb begin
        state_next = state;
        dmem_req   = 1'b0;
        dmem_we    = is_store;
        dmem_addr  = {ex_alu_result[31:2], 2'b00};
        dmem_be    = cur_be;
        dmem_wdata = cur_wdata;
        mem_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (memop && aligned) begin
                    dmem_req = 1'b1;
                    if (!dmem_ack) begin
                        mem_stall  = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                dmem_req   = 1'b1;
                dmem_we    = hold_we;
                dmem_addr  = hold_addr;
                dmem_be    = hold_be;
                dmem_wdata = hold_wdata;
                if (dmem_ack)
                    state_next = IDLE;
                else
                    mem_stall = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        if (rst)
            dmem_req = 1'b0;
    end

    // The request is frozen on entry to WAIT so the bus stays stable until ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_we    <= 1'b0;
            hold_addr  <= 32'd0;
            hold_be    <= 4'd0;
            hold_wdata <= 32'd0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && (state_next == WAIT)) begin
                hold_we    <= dmem_we;
                hold_addr  <= dmem_addr;
                hold_be    <= dmem_be;
                hold_wdata <= dmem_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_result      <= 32'd0;
            wb_rd          <= 5'd0;
            wb_reg_write   <= 1'b0;
            mem_misaligned <= 1'b0;
        end else if (mem_stall) begin
            wb_reg_write   <= 1'b0;
            mem_misaligned <= 1'b0;
        end else if (misaligned) begin
            wb_reg_write   <= 1'b0;
            mem_misaligned <= 1'b1;
        end else begin
            wb_result      <= (ex_mem_reg && is_load) ? load_value : ex_alu_result;
            wb_rd          <= ex_rd;
            wb_reg_write   <= ex_reg_write && (ex_rd != 5'd0) && !is_store;
            mem_misaligned <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues directed and random operations
// against a simple memory responder; a monitor checks each write-back result.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_alu_result, ex_rs2_data, ex_mem_instruction;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_reg;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall, wb_reg_write, mem_misaligned;
    logic [31:0] wb_result;
    logic [4:0]  wb_rd;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_reg;
        logic [2:0]  funct3;
    } op_t;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        reg_write;
        logic        misaligned;
        logic        check_data;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   active = 1'b0;
    bit   mon_pend = 1'b0;
    bit   mon_stall_pend = 1'b0;
    exp_t mon_e;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_reg(ex_mem_reg), .ex_mem_instruction(ex_mem_instruction),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_stall(mem_stall), .wb_result(wb_result), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .mem_misaligned(mem_misaligned)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    function automatic int accessBytes(input op_t op);
        if (op.mem_write)
            return (op.funct3 == 3'd0) ? 1 : (op.funct3 == 3'd1) ? 2 : 4;
        return (op.funct3 inside {3'd0, 3'd4}) ? 1 : (op.funct3 inside {3'd1, 3'd5}) ? 2 : 4;
    endfunction

    // Reference behaviour expressed as byte arithmetic on the fetched word.
    function automatic exp_t refModel(input op_t op, input logic [31:0] rdata);
        exp_t        e;
        int          n, off;
        logic [31:0] v;
        logic        sgn;
        n   = accessBytes(op);
        off = int'(op.alu[1:0]);
        e.rd = op.rd;
        e.check_data = 1'b1;
        e.misaligned = 1'b0;
        if ((op.mem_read || op.mem_write) && ((off % n) != 0)) begin
            e.misaligned = 1'b1;
            e.reg_write  = 1'b0;
            e.check_data = 1'b0;
            e.result     = 32'd0;
            return e;
        end
        v = op.alu;
        if (op.mem_reg && op.mem_read && !op.mem_write) begin
            sgn = !(op.funct3 inside {3'd4, 3'd5});
            if (n == 1) begin
                v = (rdata >> (8 * off)) & 32'hFF;
                if (sgn && v >= 32'd128) v = v - 32'd256;
            end else if (n == 2) begin
                v = (rdata >> (8 * off)) & 32'hFFFF;
                if (sgn && v >= 32'd32768) v = v - 32'd65536;
            end else begin
                v = rdata;
            end
        end
        e.result    = v;
        e.reg_write = op.reg_write && (op.rd != 5'd0) && !op.mem_write;
        return e;
    endfunction

    function automatic logic [3:0] expBe(input op_t op);
        int n, off;
        n   = accessBytes(op);
        off = int'(op.alu[1:0]);
        if (!op.mem_write) return 4'b0000;
        if (n == 1) return 4'(1 << off);
        if (n == 2) return (off >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] expWdata(input op_t op);
        int n;
        n = accessBytes(op);
        if (n == 1) return {24'd0, op.rs2[7:0]} * 32'h01010101;
        if (n == 2) return {16'd0, op.rs2[15:0]} * 32'h00010001;
        return op.rs2;
    endfunction

    function automatic op_t mkOp(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                                 input logic rw, input logic rdm, input logic wrm, input logic mreg,
                                 input logic [2:0] f3);
        op_t op;
        op.alu = alu; op.rs2 = rs2; op.rd = rd; op.reg_write = rw;
        op.mem_read = rdm; op.mem_write = wrm; op.mem_reg = mreg; op.funct3 = f3;
        return op;
    endfunction

    function automatic op_t randomOp();
        op_t op;
        int  kind;
        kind = $urandom_range(0, 3);
        op.alu = $urandom;
        if ($urandom_range(0, 1) == 1) op.alu[1:0] = 2'b00;
        op.rs2 = $urandom;
        op.rd = 5'($urandom);
        op.reg_write = 1'($urandom);
        case ($urandom_range(0, 5))
            0: op.funct3 = 3'd0;
            1: op.funct3 = 3'd1;
            2: op.funct3 = 3'd2;
            3: op.funct3 = 3'd4;
            4: op.funct3 = 3'd5;
            default: op.funct3 = 3'($urandom);
        endcase
        op.mem_read  = (kind == 1) || (kind == 3);
        op.mem_write = (kind == 2) || (kind == 3);
        op.mem_reg   = (kind == 1);
        return op;
    endfunction

    task automatic setNop();
        ex_alu_result = 32'd0; ex_rs2_data = 32'd0; ex_rd = 5'd0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_reg = 1'b0;
        ex_mem_instruction = 32'd0;
    endtask

    // Issues one operation and plays the memory side with the given ack latency.
    task automatic applyStimulus(input op_t op, input int lat, input logic [31:0] rdata);
        exp_t e;
        bit   req;
        e   = refModel(op, rdata);
        req = (op.mem_read || op.mem_write) && !e.misaligned;
        sb_q.push_back(e);
        @(posedge clk); #1;
        ex_alu_result = op.alu; ex_rs2_data = op.rs2; ex_rd = op.rd;
        ex_reg_write = op.reg_write; ex_mem_read = op.mem_read; ex_mem_write = op.mem_write;
        ex_mem_reg = op.mem_reg;
        ex_mem_instruction = {17'($urandom), op.funct3, 12'($urandom)};
        active = 1'b1;
        if (!req) begin
            dmem_ack = 1'($urandom);
            dmem_rdata = $urandom;
            @(negedge clk);
            checkBit("idle_req", dmem_req, 1'b0);
            checkBit("idle_stall", mem_stall, 1'b0);
        end else begin
            for (int k = 0; k <= lat; k++) begin
                if (k > 0) begin
                    @(posedge clk); #1;
                end
                dmem_ack = (k == lat);
                dmem_rdata = (k == lat) ? rdata : $urandom;
                @(negedge clk);
                checkBit("req", dmem_req, 1'b1);
                checkBit("stall", mem_stall, k < lat);
                checkBit("we", dmem_we, op.mem_write);
                checkOutput("addr", dmem_addr, {op.alu[31:2], 2'b00});
                checkOutput("be", {28'd0, dmem_be}, {28'd0, expBe(op)});
                if (op.mem_write) checkOutput("wdata", dmem_wdata, expWdata(op));
            end
        end
    endtask

    task automatic drain();
        @(posedge clk); #1;
        active = 1'b0;
        setNop();
        dmem_ack = 1'b0;
        @(negedge clk); #1;
        checkOutput("scoreboard_empty", sb_q.size(), 32'd0);
    endtask

    // Pops one expectation for every edge on which the stage was not stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_pend) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_wb: got a write-back expected none");
                end else begin
                    mon_e = sb_q.pop_front();
                    checkBit("wb_reg_write", wb_reg_write, mon_e.reg_write);
                    checkBit("mem_misaligned", mem_misaligned, mon_e.misaligned);
                    if (mon_e.check_data) begin
                        checkOutput("wb_result", wb_result, mon_e.result);
                        checkOutput("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
                    end
                end
            end
            if (mon_stall_pend) checkBit("stall_bubble", wb_reg_write, 1'b0);
            mon_pend       = active && !rst && !mem_stall;
            mon_stall_pend = active && !rst && mem_stall;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        setNop();
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        #3;
        checkBit("rst_req", dmem_req, 1'b0);
        checkOutput("rst_wb_result", wb_result, 32'd0);
        checkOutput("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        checkBit("rst_wb_reg_write", wb_reg_write, 1'b0);
        checkBit("rst_misaligned", mem_misaligned, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(mkOp(32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2), 3, 32'hDEADBEEF);
        applyStimulus(mkOp(32'h203, 32'hA5, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0), 0, 32'h0);
        applyStimulus(mkOp(32'h1, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0), 1, 32'h00008000);
        applyStimulus(mkOp(32'h1, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4), 0, 32'h00008000);
        applyStimulus(mkOp(32'h2, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1), 2, 32'h80000000);
        applyStimulus(mkOp(32'h102, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2), 0, 32'h12345678);
        applyStimulus(mkOp(32'h1234, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), 0, 32'h0);
        applyStimulus(mkOp(32'h402, 32'hBEEF1234, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1), 1, 32'h0);
        for (int i = 0; i < 60; i++)
            applyStimulus(randomOp(), $urandom_range(0, 3), $urandom);
        drain();

        // Abandon a pending load with reset, then offer a stray ack.
        @(posedge clk); #1;
        ex_alu_result = 32'h300; ex_rd = 5'd9; ex_reg_write = 1'b1;
        ex_mem_read = 1'b1; ex_mem_reg = 1'b1; ex_mem_instruction = 32'h0000_2003;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkBit("wait_req", dmem_req, 1'b1);
        checkBit("wait_stall", mem_stall, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkBit("rst_wait_req", dmem_req, 1'b0);
        checkBit("rst_wait_wb_reg_write", wb_reg_write, 1'b0);
        checkOutput("rst_wait_wb_result", wb_result, 32'd0);
        setNop();
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = $urandom;
        @(negedge clk);
        checkBit("stray_ack_req", dmem_req, 1'b0);
        checkBit("stray_ack_stall", mem_stall, 1'b0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        checkBit("stray_ack_wb_reg_write", wb_reg_write, 1'b0);
        checkOutput("stray_ack_wb_result", wb_result, 32'd0);
        checkOutput("stray_ack_wb_rd", {27'd0, wb_rd}, 32'd0);

        for (int i = 0; i < 20; i++)
            applyStimulus(randomOp(), $urandom_range(0, 3), $urandom);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 ex_alu_result  in  32  effective address (load/store) or ALU result.
REQ-004 ex_rs2_data  in  32  store data.
REQ-005 ex_rd  in  5  destination register.
REQ-006 ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_reg  in  1 each  control from EX/MEM register.
REQ-007 ex_mem_instruction  in  32  instruction; bits [14:12] (funct3) select access size/sign.
REQ-008 dmem_req  out  1  data-memory request valid.
REQ-009 dmem_we  out  1  1 = write, 0 = read.
REQ-010 dmem_addr  out  32  word address; {ex_alu_result[31:2],2'b00}.
REQ-011 dmem_be  out  4  byte enables (writes); 4'b0000 on reads.
REQ-012 dmem_wdata  out  32  lane-aligned store data.
REQ-013 dmem_rdata  in  32  read word, valid when dmem_ack=1.
REQ-014 dmem_ack  in  1  one-cycle completion pulse for the outstanding request.
REQ-015 mem_stall  out  1  freeze IF/ID/EX and hold EX/MEM inputs stable.
REQ-016 wb_result  out  32  registered MEM/WB write-back value.
REQ-017 wb_rd  out  5  registered destination.
REQ-018 wb_reg_write  out  1  registered write enable.
REQ-019 mem_misaligned  out  1  registered one-cycle fault pulse.

Function
REQ-020 FSM states IDLE, WAIT; reset state IDLE.
REQ-021 memop = ex_mem_read | ex_mem_write; ex_mem_write wins if both set (access is a store).
REQ-022 IDLE, memop, aligned: dmem_req=1 combinationally from current inputs; dmem_ack same cycle completes; otherwise go WAIT.
REQ-023 WAIT: dmem_req=1 with dmem_we/addr/be/wdata held from registered copies latched on IDLE->WAIT; on dmem_ack complete and return IDLE.
REQ-024 mem_stall = (IDLE & memop & aligned & !dmem_ack) | (WAIT & !dmem_ack).
REQ-025 Non-memory op or completion: next edge wb_result/wb_rd/wb_reg_write load new values (latency 1 cycle).
REQ-026 Stalled cycle: wb_reg_write <= 0 (bubble); wb_result, wb_rd hold.
REQ-027 wb_result = ex_mem_reg ? load value : ex_alu_result; stores and non-mem ops write ex_alu_result.
REQ-028 wb_reg_write = ex_reg_write & (ex_rd != 0); stores force 0.
REQ-029 Stores: SB(000) be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH(001) be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}; SW(010) be=1111, wdata=rs2.
REQ-030 Loads: LB(000)/LBU(100) select byte addr[1:0], sign/zero extend; LH(001)/LHU(101) select half addr[1], sign/zero extend; LW(010) full word; any other funct3 treated as LW.
REQ-031 Misaligned: halfword with addr[0]=1 or word with addr[1:0]!=0; no dmem_req, no stall, wb_reg_write<=0, mem_misaligned<=1 for one cycle.
REQ-032 dmem_ack while IDLE without a request is ignored.
REQ-033 Only one request outstanding; dmem_req remains 1 continuously from issue to ack.

Reset
REQ-034 On rst: state IDLE; dmem_req=0; wb_result=0, wb_rd=0, wb_reg_write=0, mem_misaligned=0; held registers cleared.
REQ-035 Reset during WAIT abandons the request; a subsequent stray dmem_ack is ignored per REQ-032.

Verification
REQ-036 LW addr 0x100, ack 3 cycles later with rdata 0xDEADBEEF, rd=5 -> mem_stall high 3 cycles, wb_result=0xDEADBEEF, wb_rd=5, wb_reg_write=1 one cycle after ack; wb_reg_write=0 during stall.
REQ-037 SB rs2=0x000000A5 addr 0x203, ack same cycle -> be=1000, wdata=0xA5A5A5A5, dmem_we=1, no stall, wb_reg_write=0.
REQ-038 LB addr 0x1 rdata 0x00008000 vs LBU same -> wb_result 0xFFFFFF80 vs 0x00000080; LH addr 0x2 rdata 0x80000000 -> 0xFFFF8000.
REQ-039 LW addr 0x102 -> no dmem_req, mem_misaligned pulses 1 cycle, wb_reg_write=0.
REQ-040 Assert rst in WAIT, then ack next cycle -> outputs zero, state IDLE, no write-back produced.
REQ-041 ADD result 0x1234, rd=0, reg_write=1 -> wb_result=0x1234, wb_reg_write=0, no dmem_req.
